// File: rtl/tick_period_monitor_if.sv
// Signal bundle between the clock-divider tick source and tick_period_monitor.
// Optional min/max period outputs exist only when TICK_MON_MINMAX_EN is defined.
interface tick_period_monitor_if #(
    parameter int CW = 26
);
    logic          tick_in;
    logic          fault_clr;
    logic [CW-1:0] period_out;
    logic          period_valid;
    logic          locked;
    logic          fault;
    logic          timeout;
    logic [7:0]    fault_cnt;
`ifdef TICK_MON_MINMAX_EN
    logic [CW-1:0] min_period;
    logic [CW-1:0] max_period;

    modport master (
        output tick_in, fault_clr,
        input  period_out, period_valid, locked, fault, timeout, fault_cnt,
        input  min_period, max_period
    );
    modport slave (
        input  tick_in, fault_clr,
        output period_out, period_valid, locked, fault, timeout, fault_cnt,
        output min_period, max_period
    );
`else
    modport master (
        output tick_in, fault_clr,
        input  period_out, period_valid, locked, fault, timeout, fault_cnt
    );
    modport slave (
        input  tick_in, fault_clr,
        output period_out, period_valid, locked, fault, timeout, fault_cnt
    );
`endif
endinterface

// File: rtl/tick_period_monitor.sv
// Measures clk10 cycles between divider ticks, grades each period and tracks lock/fault.
// Optional min/max period tracking is enabled by defining TICK_MON_MINMAX_EN.
module tick_period_monitor #(
    parameter int EXPECTED   = 10000000,
    parameter int TOLERANCE  = 2,
    parameter int LOCK_COUNT = 4,
    parameter int CW         = 26
) (
    input  logic                  clk10,
    input  logic                  reset,
    tick_period_monitor_if.slave  mon
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

    // Window bounds live at CW+1 bits so EXPECTED-TOLERANCE and the saturated period never wrap.
    localparam logic [CW:0]   PERIOD_LO   = (EXPECTED > TOLERANCE) ? (CW+1)'(EXPECTED - TOLERANCE) : '0;
    localparam logic [CW:0]   PERIOD_HI   = (CW+1)'(EXPECTED + TOLERANCE);
    localparam logic [CW-1:0] TIMEOUT_AT  = CW'(EXPECTED + TOLERANCE - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;
    localparam logic [3:0]    LOCK_TARGET = 4'(LOCK_COUNT);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          seen;
    logic [3:0]    good_cnt, good_cnt_nxt;
    logic [7:0]    fault_cnt_q, fault_cnt_nxt;
    logic [CW-1:0] period_q;
    logic          period_valid_q, locked_q, fault_q, timeout_q;

    logic [CW:0]   period_ext;
    logic [CW-1:0] period_sat;
    logic          period_good, overdue, capture;

    assign period_ext  = {1'b0, cnt} + (CW+1)'(1);
    assign period_sat  = period_ext[CW] ? CNT_MAX : period_ext[CW-1:0];
    assign period_good = (period_ext >= PERIOD_LO) && (period_ext <= PERIOD_HI);
    assign overdue     = !mon.tick_in && seen && (cnt == TIMEOUT_AT);
    assign capture     = mon.tick_in && seen;

    // NOTE: sequential state uses non-blocking assignments and a synchronous active-low reset.
    always_ff @(posedge clk10) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block is given a default first, so no latch can be inferred.
    always_comb begin
        state_nxt     = state;
        good_cnt_nxt  = good_cnt;
        fault_cnt_nxt = fault_cnt_q;
        case (state)
            IDLE: begin
                if (mon.tick_in) begin
                    state_nxt    = ACQUIRE;
                    good_cnt_nxt = '0;
                end
            end
            ACQUIRE: begin
                if (overdue) begin
                    state_nxt    = IDLE;
                    good_cnt_nxt = '0;
                end else if (mon.tick_in) begin
                    if (period_good) begin
                        good_cnt_nxt = good_cnt + 4'd1;
                        if (good_cnt + 4'd1 == LOCK_TARGET) state_nxt = LOCKED;
                    end else begin
                        good_cnt_nxt = '0;
                    end
                end
            end
            LOCKED: begin
                if (overdue || (mon.tick_in && !period_good)) begin
                    state_nxt = FAULT;
                    if (fault_cnt_q != 8'hFF) fault_cnt_nxt = fault_cnt_q + 8'd1;
                end
            end
            FAULT: begin
                if (mon.fault_clr) begin
                    state_nxt    = IDLE;
                    good_cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk10) begin
        if (!reset) begin
            cnt            <= '0;
            seen           <= 1'b0;
            good_cnt       <= '0;
            fault_cnt_q    <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            fault_q        <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            if (mon.tick_in)         cnt <= '0;
            else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
            if (mon.tick_in) seen <= 1'b1;
            if (capture) period_q <= period_sat;
            period_valid_q <= capture;
            timeout_q      <= overdue;
            good_cnt       <= good_cnt_nxt;
            fault_cnt_q    <= fault_cnt_nxt;
            locked_q       <= (state_nxt == LOCKED);
            fault_q        <= (state_nxt == FAULT);
        end
    end

    assign mon.period_out   = period_q;
    assign mon.period_valid = period_valid_q;
    assign mon.locked       = locked_q;
    assign mon.fault        = fault_q;
    assign mon.timeout      = timeout_q;
    assign mon.fault_cnt    = fault_cnt_q;

`ifdef TICK_MON_MINMAX_EN
    logic [CW-1:0] min_q, max_q;
    logic          clr_stats;

    assign clr_stats = (state == FAULT) && mon.fault_clr;

    always_ff @(posedge clk10) begin
        if (!reset || clr_stats) begin
            min_q <= '1;
            max_q <= '0;
        end else if (capture) begin
            if (period_sat < min_q) min_q <= period_sat;
            if (period_sat > max_q) max_q <= period_sat;
        end
    end

    assign mon.min_period = min_q;
    assign mon.max_period = max_q;
`endif
endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench for tick_period_monitor with EXPECTED=10, TOLERANCE=1, LOCK_COUNT=4, CW=8.
module tb_tick_period_monitor;
    localparam int CW = 8;

    logic clk10 = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tick_period_monitor_if #(.CW(CW)) mon_if ();

    tick_period_monitor #(
        .EXPECTED(10), .TOLERANCE(1), .LOCK_COUNT(4), .CW(CW)
    ) dut (
        .clk10 (clk10),
        .reset (reset),
        .mon   (mon_if.slave)
    );

    always #5 clk10 = ~clk10;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk10);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One-cycle tick; returns just after the edge that samples it.
    task automatic tick_cycle();
        mon_if.tick_in = 1'b1;
        step();
        mon_if.tick_in = 1'b0;
    endtask

    task automatic test_reset();
        mon_if.tick_in   = 1'b0;
        mon_if.fault_clr = 1'b0;
        reset            = 1'b0;
        idle(3);
        checks++; if (mon_if.period_out !== 8'd0) begin errors++; $display("FAIL rst_period_out: got %0d exp 0", mon_if.period_out); end
        checks++; if (mon_if.period_valid !== 1'b0) begin errors++; $display("FAIL rst_period_valid: got %0b exp 0", mon_if.period_valid); end
        checks++; if (mon_if.locked !== 1'b0) begin errors++; $display("FAIL rst_locked: got %0b exp 0", mon_if.locked); end
        checks++; if (mon_if.fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %0b exp 0", mon_if.fault); end
        checks++; if (mon_if.timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %0b exp 0", mon_if.timeout); end
        checks++; if (mon_if.fault_cnt !== 8'd0) begin errors++; $display("FAIL rst_fault_cnt: got %0d exp 0", mon_if.fault_cnt); end
`ifdef TICK_MON_MINMAX_EN
        checks++; if (mon_if.min_period !== 8'hFF) begin errors++; $display("FAIL rst_min: got %0d exp 255", mon_if.min_period); end
        checks++; if (mon_if.max_period !== 8'd0) begin errors++; $display("FAIL rst_max: got %0d exp 0", mon_if.max_period); end
`endif
    endtask

    task automatic test_lock();
        logic exp_lock;
        reset = 1'b1;
        tick_cycle();
        checks++; if (mon_if.period_valid !== 1'b0) begin errors++; $display("FAIL first_tick_valid: got %0b exp 0", mon_if.period_valid); end
        for (int k = 2; k <= 5; k++) begin
            idle(9);
            tick_cycle();
            exp_lock = (k == 5);
            checks++; if (mon_if.period_valid !== 1'b1) begin errors++; $display("FAIL lock_valid_t%0d: got %0b exp 1", k, mon_if.period_valid); end
            checks++; if (mon_if.period_out !== 8'd10) begin errors++; $display("FAIL lock_period_t%0d: got %0d exp 10", k, mon_if.period_out); end
            checks++; if (mon_if.locked !== exp_lock) begin errors++; $display("FAIL lock_state_t%0d: got %0b exp %0b", k, mon_if.locked, exp_lock); end
        end
        step();
        checks++; if (mon_if.period_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: got %0b exp 0", mon_if.period_valid); end
    endtask

    task automatic test_bad_period();
        idle(6);
        tick_cycle();
        checks++; if (mon_if.period_out !== 8'd8) begin errors++; $display("FAIL bad_period_out: got %0d exp 8", mon_if.period_out); end
        checks++; if (mon_if.fault !== 1'b1) begin errors++; $display("FAIL bad_fault: got %0b exp 1", mon_if.fault); end
        checks++; if (mon_if.locked !== 1'b0) begin errors++; $display("FAIL bad_locked: got %0b exp 0", mon_if.locked); end
        checks++; if (mon_if.fault_cnt !== 8'd1) begin errors++; $display("FAIL bad_fault_cnt: got %0d exp 1", mon_if.fault_cnt); end
        mon_if.fault_clr = 1'b1;
        step();
        mon_if.fault_clr = 1'b0;
        checks++; if (mon_if.fault !== 1'b0) begin errors++; $display("FAIL bad_clr_fault: got %0b exp 0", mon_if.fault); end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        int first  = 0;
        tick_cycle();
        for (int k = 0; k < 4; k++) begin
            idle(9);
            tick_cycle();
        end
        checks++; if (mon_if.locked !== 1'b1) begin errors++; $display("FAIL to_relock: got %0b exp 1", mon_if.locked); end
        for (int i = 1; i <= 30; i++) begin
            step();
            if (mon_if.timeout === 1'b1) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        checks++; if (first !== 11) begin errors++; $display("FAIL to_cycle: got %0d exp 11", first); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL to_pulses: got %0d exp 1", pulses); end
        checks++; if (mon_if.fault !== 1'b1) begin errors++; $display("FAIL to_fault: got %0b exp 1", mon_if.fault); end
        checks++; if (mon_if.fault_cnt !== 8'd2) begin errors++; $display("FAIL to_fault_cnt: got %0d exp 2", mon_if.fault_cnt); end
        mon_if.fault_clr = 1'b1;
        step();
        mon_if.fault_clr = 1'b0;
        checks++; if (mon_if.fault !== 1'b0) begin errors++; $display("FAIL to_clr_fault: got %0b exp 0", mon_if.fault); end
    endtask

    task automatic test_acquire();
        int   periods [7] = '{10, 10, 12, 10, 10, 10, 10};
        logic exp_lock [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tick_cycle();
        for (int k = 0; k < 7; k++) begin
            idle(periods[k] - 1);
            tick_cycle();
            checks++; if (mon_if.period_out !== 8'(periods[k])) begin errors++; $display("FAIL acq_period_%0d: got %0d exp %0d", k, mon_if.period_out, periods[k]); end
            checks++; if (mon_if.locked !== exp_lock[k]) begin errors++; $display("FAIL acq_locked_%0d: got %0b exp %0b", k, mon_if.locked, exp_lock[k]); end
        end
    endtask

    task automatic test_reset_mid();
        idle(4);
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++; if (mon_if.locked !== 1'b0) begin errors++; $display("FAIL mid_locked: got %0b exp 0", mon_if.locked); end
        checks++; if (mon_if.period_out !== 8'd0) begin errors++; $display("FAIL mid_period_out: got %0d exp 0", mon_if.period_out); end
        checks++; if (mon_if.fault_cnt !== 8'd0) begin errors++; $display("FAIL mid_fault_cnt: got %0d exp 0", mon_if.fault_cnt); end
        tick_cycle();
        checks++; if (mon_if.period_valid !== 1'b0) begin errors++; $display("FAIL mid_first_valid: got %0b exp 0", mon_if.period_valid); end
        idle(9);
        tick_cycle();
        checks++; if (mon_if.period_valid !== 1'b1) begin errors++; $display("FAIL mid_second_valid: got %0b exp 1", mon_if.period_valid); end
        checks++; if (mon_if.period_out !== 8'd10) begin errors++; $display("FAIL mid_second_period: got %0d exp 10", mon_if.period_out); end
    endtask

    // Continues from the single 10-cycle period after the mid-run reset: 10,9,11,10.
    task automatic test_tolerance_edges();
        int   periods [3] = '{9, 11, 10};
        logic exp_lock [3] = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            idle(periods[k] - 1);
            tick_cycle();
            checks++; if (mon_if.period_out !== 8'(periods[k])) begin errors++; $display("FAIL tol_period_%0d: got %0d exp %0d", k, mon_if.period_out, periods[k]); end
            checks++; if (mon_if.locked !== exp_lock[k]) begin errors++; $display("FAIL tol_locked_%0d: got %0b exp %0b", k, mon_if.locked, exp_lock[k]); end
        end
`ifdef TICK_MON_MINMAX_EN
        checks++; if (mon_if.min_period !== 8'd9) begin errors++; $display("FAIL tol_min: got %0d exp 9", mon_if.min_period); end
        checks++; if (mon_if.max_period !== 8'd11) begin errors++; $display("FAIL tol_max: got %0d exp 11", mon_if.max_period); end
`endif
    endtask

    task automatic test_saturation();
        idle(299);
        tick_cycle();
        checks++; if (mon_if.period_valid !== 1'b1) begin errors++; $display("FAIL sat_valid: got %0b exp 1", mon_if.period_valid); end
        checks++; if (mon_if.period_out !== 8'd255) begin errors++; $display("FAIL sat_period: got %0d exp 255", mon_if.period_out); end
        checks++; if (mon_if.fault !== 1'b1) begin errors++; $display("FAIL sat_fault: got %0b exp 1", mon_if.fault); end
        checks++; if (mon_if.fault_cnt !== 8'd1) begin errors++; $display("FAIL sat_fault_cnt: got %0d exp 1", mon_if.fault_cnt); end
    endtask

    task automatic test_back_to_back();
        idle(9);
        mon_if.fault_clr = 1'b1;
        tick_cycle();
        mon_if.fault_clr = 1'b0;
        checks++; if (mon_if.fault !== 1'b0) begin errors++; $display("FAIL b2b_fault: got %0b exp 0", mon_if.fault); end
        checks++; if (mon_if.locked !== 1'b0) begin errors++; $display("FAIL b2b_locked: got %0b exp 0", mon_if.locked); end
        checks++; if (mon_if.period_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b exp 1", mon_if.period_valid); end
        checks++; if (mon_if.period_out !== 8'd10) begin errors++; $display("FAIL b2b_period: got %0d exp 10", mon_if.period_out); end
        for (int k = 0; k < 5; k++) begin
            idle(9);
            tick_cycle();
        end
        checks++; if (mon_if.locked !== 1'b1) begin errors++; $display("FAIL b2b_relock: got %0b exp 1", mon_if.locked); end
        mon_if.fault_clr = 1'b1;
        step();
        mon_if.fault_clr = 1'b0;
        checks++; if (mon_if.locked !== 1'b1) begin errors++; $display("FAIL clr_ignored_locked: got %0b exp 1", mon_if.locked); end
        checks++; if (mon_if.fault_cnt !== 8'd1) begin errors++; $display("FAIL clr_ignored_cnt: got %0d exp 1", mon_if.fault_cnt); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_bad_period();
        test_timeout();
        test_acquire();
        test_reset_mid();
        test_tolerance_edges();
        test_saturation();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tick_period_monitor.md
Name: tick_period_monitor

Overview:
- Receive-side checker for the one-cycle clock-enable ticks produced by the lab clock divider.
- Counts clk10 cycles between consecutive ticks and publishes each measured period.
- Compares each period against an expected divide ratio, tracks lock and fault status, and flags missing ticks.
- Sits downstream of the divider. Drives the lock/fault LEDs and feeds the period value to the display path.

Parameters:
- EXPECTED, 10000000, nominal clk10 cycles per tick.
- TOLERANCE, 2, allowed absolute deviation in cycles; a period is good when EXPECTED-TOLERANCE <= period <= EXPECTED+TOLERANCE.
- LOCK_COUNT, 4, consecutive good periods needed to declare lock (1..15).
- CW, 26, width of the cycle counter and the period output.

Ports:
- clk10  input  1  system clock
- reset  input  1  synchronous, active-low reset
- tick_in  input  1  single-cycle enable pulse under test
- fault_clr  input  1  clears FAULT state; level-sampled
- period_out  output  CW  last measured period in clk10 cycles
- period_valid  output  1  one-cycle pulse when period_out updates
- locked  output  1  high while state is LOCKED
- fault  output  1  high while state is FAULT
- timeout  output  1  one-cycle pulse when the tick is overdue
- fault_cnt  output  8  saturating count of entries into FAULT

Behaviour:
- Clock and reset: reset is synchronous, active-low; clock is clk10.
- Reset values:
  - Outputs: period_out=0, period_valid=0, locked=0, fault=0, timeout=0, fault_cnt=0.
  - Internal: cnt=0, good_cnt=0, seen=0, state=IDLE.
- Counter rules:
  - Edge with tick_in=1: cnt<=0.
  - Otherwise: cnt<=cnt+1, saturating at 2^CW-1 with no wrap.
- Period capture:
  - On an edge with tick_in=1 and seen=1: period_out<=cnt+1 and period_valid=1 for that cycle.
  - Ticks N cycles apart therefore give period_out=N. Latency: period visible one cycle after the tick edge.
  - The first tick after reset sets seen=1 and captures nothing.
- Period quality: good = (cnt+1) within [EXPECTED-TOLERANCE, EXPECTED+TOLERANCE]. Compute at CW+1 bits to avoid underflow.
- Timeout:
  - Edge with tick_in=0, seen=1 and cnt==EXPECTED+TOLERANCE-1 pulses timeout for one cycle.
  - Fires once per overdue interval, because cnt moves past the compare value.
- State machine:
  - IDLE: tick_in → ACQUIRE with good_cnt=0. No period evaluation in this state.
  - ACQUIRE:
    - Good tick: good_cnt+1; when it reaches LOCK_COUNT → LOCKED.
    - Bad tick: good_cnt=0, remain in ACQUIRE.
    - Timeout: → IDLE, good_cnt=0.
  - LOCKED: bad tick or timeout → FAULT, fault_cnt+1 (saturates at 255).
  - FAULT: ticks keep updating period_out; state is held until fault_clr=1, then → IDLE.
- Outputs: locked and fault are registered decodes of the state.
- Simultaneous events:
  - fault_clr in FAULT with tick_in in the same cycle: fault_clr wins, next state IDLE. cnt still clears and period still captures.
  - fault_clr in any other state: ignored.
  - tick_in and the timeout compare cannot coincide, because timeout requires tick_in=0.
- Saturation: with cnt saturated, a later tick reports period 2^CW. Because period_out is CW bits, it shows 2^CW-1. Classified bad.
- Reset mid-operation: all state and outputs return to reset values at the next edge with reset=0. Any in-flight measurement is discarded.

Optional Feature:
- Macro: TICK_MON_MINMAX_EN.
- Defined:
  - Adds outputs min_period[CW-1:0] (reset all-ones) and max_period[CW-1:0] (reset 0).
  - Both update on every period_valid pulse with the new period, if smaller or larger respectively.
  - fault_clr in FAULT also reloads both to their reset values.
- Undefined: ports and registers are absent; all other behaviour is identical.

Test Plan (EXPECTED=10, TOLERANCE=1, LOCK_COUNT=4, CW=8):
- Ticks every 10 cycles from reset release → no period_valid on tick 1; period_out=10 on each later tick; locked=1 the cycle after tick 5.
- Locked, one tick arrives 8 cycles after the previous → period_out=8, fault=1, locked=0, fault_cnt=1; fault_clr pulse → IDLE, fault=0.
- Locked, ticks stop → timeout pulses exactly once, 11 cycles after the last tick; fault=1; no further timeout pulses.
- During ACQUIRE, periods 10,10,12,10,10,10,10 → good_cnt resets on 12; locked asserts after the 4th consecutive 10 following it.
- reset=0 for one cycle mid-LOCKED → all outputs 0 next cycle; next tick captures nothing; period_valid returns on the following tick.
- With TICK_MON_MINMAX_EN, periods 10,9,11,10 → min_period=9, max_period=11; periods 9 and 11 sit at the tolerance edges and are classified good.
